aes_iter_engine: RTL

AES_ITER_ENGINE -- requirements
Module: aes_iter_engine

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_round_step.sv | 67 ++++++
 rtl/aes_iter_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 helpers for the iterative engine.
//   state_e        : engine FSM state encoding (IDLE / BUSY / DONE)
//   xtime, gf_mul  : GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1
//   sbox           : forward S-box (multiplicative inverse + affine map)
//   rcon           : round-constant table, index 0 => round 1
//   unroll_legal   : elaboration-time check of the UNROLL parameter
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] AES_ROUNDS = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Inverse computed as x^254 (square-and-multiply over x^2..x^128);
  // x=0 naturally maps to 0 before the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic bit unroll_legal(input int u);
    return (u == 1) || (u == 2) || (u == 5) || (u == 10);
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// One AES-128 encryption round plus the matching key-expansion step.
//   state_i : state entering the round (FIPS-197 byte order, byte 0 in [127:120])
//   key_i   : previous round key
//   rcon_i  : round constant for the key produced here
//   final_i : 1 for round 10, which skips MixColumns
//   state_o : state after AddRoundKey with key_o
//   key_o   : round key for this round
module aes_round_step
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  input  logic         final_i,
  output logic [127:0] state_o,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3, tw, n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];
  // RotWord then SubWord on the last word, Rcon into the leading byte.
  assign tw = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon_i, 24'h000000};
  assign n0 = w0 ^ tw;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_o = {n0, n1, n2, n3};

  logic [7:0] sb_b [16];
  logic [7:0] sr_b [16];
  logic [7:0] mc_b [16];
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    sb_b = '{default: 8'h00};
    sr_b = '{default: 8'h00};
    mc_b = '{default: 8'h00};
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    state_o = '0;
    for (int i = 0; i < 16; i++) sb_b[i] = sbox(state_i[127-8*i -: 8]);
    // Byte index r+4c holds row r, column c; row r rotates left by r.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr_b[r+4*c] = sb_b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr_b[4*c];
      a1 = sr_b[4*c+1];
      a2 = sr_b[4*c+2];
      a3 = sr_b[4*c+3];
      mc_b[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc_b[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc_b[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc_b[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int i = 0; i < 16; i++)
      state_o[127-8*i -: 8] = (final_i ? sr_b[i] : mc_b[i]) ^ key_o[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_iter_engine.sv
// Iterative AES-128 encryption engine, UNROLL rounds per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : plaintext/key handshake, accepted only in IDLE
//   in_data, in_key     : plaintext and cipher key, byte 0 in [127:120]
//   out_valid/out_ready : ciphertext handshake, out_valid only in DONE
//   out_data            : ciphertext (the state register)
//   abort               : cancel request, only when AES_ABORT_EN is defined
// Optional feature macro: AES_ABORT_EN.
module aes_iter_engine
  import aes_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_ABORT_EN
  ,
  input  logic         abort
`endif
);

  if (!unroll_legal(UNROLL)) begin : g_bad_unroll
    $error("aes_iter_engine: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] STEP = 4'(UNROLL);

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] chain_state, chain_key;
  logic         abort_w;

`ifdef AES_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Chain of UNROLL round steps; slot j computes round round_q+j+1.
  for (genvar j = 0; j < UNROLL; j++) begin : g_step
    logic [127:0] st_in, key_in, st_out, key_out;
    logic [3:0]   rnd_j;
    if (j == 0) begin : g_first
      assign st_in  = state_q;
      assign key_in = key_q;
    end else begin : g_next
      assign st_in  = g_step[j-1].st_out;
      assign key_in = g_step[j-1].key_out;
    end
    assign rnd_j = round_q + 4'(j);
    aes_round_step u_step (
      .state_i (st_in),
      .key_i   (key_in),
      .rcon_i  (rcon(rnd_j)),
      .final_i (rnd_j == AES_ROUNDS - 4'd1),
      .state_o (st_out),
      .key_o   (key_out)
    );
  end

  assign chain_state = g_step[UNROLL-1].st_out;
  assign chain_key   = g_step[UNROLL-1].key_out;
  assign out_data    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    key_d     = key_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        // A pending abort blocks acceptance even though nothing is in flight.
        in_ready = !abort_w;
        if (in_valid && !abort_w) begin
          state_d = in_data ^ in_key;
          key_d   = in_key;
          round_d = 4'd0;
          fsm_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        state_d = chain_state;
        key_d   = chain_key;
        round_d = round_q + STEP;
        if (round_q + STEP == AES_ROUNDS) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = !abort_w;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
    if (abort_w && fsm_q != ST_IDLE) fsm_d = ST_IDLE;
  end

endmodule
